// File: rtl/xreg_field.sv
// One register field: flop plus HW/SW update arbitration, registered read data,
// change pulse and sticky collision flag. Update and read latency 1 cycle; no backpressure.
`ifndef SW_RO
`define SW_RO  0
`define SW_RW  1
`define SW_WO  2
`define SW_W1C 3
`define SW_W1S 4
`define SW_RC  5
`endif

module xreg_field #(
  parameter int                 F_WIDTH = 4,
  parameter logic [F_WIDTH-1:0] RST_VAL = '0,
  parameter int                 SW_TYPE = `SW_RW,
  parameter bit                 HW_PRI  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_wr,
  input  logic               sw_rd,
  input  logic [F_WIDTH-1:0] sw_wdata,
  input  logic               hw_modify,
  input  logic [F_WIDTH-1:0] nxt_hw_value,
  input  logic               collision_clr,
  output logic [F_WIDTH-1:0] field_value,
  output logic [F_WIDTH-1:0] sw_rdata,
  output logic               rd_valid,
  output logic               field_changed,
  output logic               collision
);

  logic               sw_upd;
  logic [F_WIDTH-1:0] sw_cand;
  logic [F_WIDTH-1:0] field_nxt;
  logic [F_WIDTH-1:0] rd_dat;

  always_comb begin
    sw_upd  = 1'b0;
    sw_cand = field_value;
    case (SW_TYPE)
      `SW_RW, `SW_WO: begin
        sw_upd  = sw_wr;
        sw_cand = sw_wdata;
      end
      `SW_W1C: begin
        sw_upd  = sw_wr;
        sw_cand = field_value & ~sw_wdata;
      end
      `SW_W1S: begin
        sw_upd  = sw_wr;
        sw_cand = field_value | sw_wdata;
      end
      `SW_RC: begin
        sw_upd  = sw_rd;
        sw_cand = '0;
      end
      default: begin
        sw_upd  = 1'b0;
        sw_cand = field_value;
      end
    endcase
  end

  // On a collision the loser is dropped entirely, never merged.
  always_comb begin
    field_nxt = field_value;
    if (sw_upd && (!hw_modify || !HW_PRI))
      field_nxt = sw_cand;
    else if (hw_modify)
      field_nxt = nxt_hw_value;
  end

  assign rd_dat = (SW_TYPE == `SW_WO) ? '0 : field_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      field_value   <= RST_VAL;
      sw_rdata      <= '0;
      rd_valid      <= 1'b0;
      field_changed <= 1'b0;
      collision     <= 1'b0;
    end else begin
      field_value   <= field_nxt;
      rd_valid      <= sw_rd;
      field_changed <= (field_nxt != field_value);
      if (sw_rd)
        sw_rdata <= rd_dat;
      // Set beats a simultaneous clear.
      if (hw_modify && sw_upd)
        collision <= 1'b1;
      else if (collision_clr)
        collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xreg_field.sv
// Drives several xreg_field variants side by side and compares every output
// each cycle against a per-instance behavioural model.
`ifndef SW_RO
`define SW_RO  0
`define SW_RW  1
`define SW_WO  2
`define SW_W1C 3
`define SW_W1S 4
`define SW_RC  5
`endif

module tb_xreg_field;
  localparam int N = 7;
  // instance: 0 RW/hw, 1 W1C/hw, 2 RC/hw, 3 RC/sw, 4 WO/hw, 5 RO/hw, 6 W1S/sw
  localparam logic [N*3-1:0] TYS = {3'd`SW_W1S, 3'd`SW_RO, 3'd`SW_WO, 3'd`SW_RC,
                                    3'd`SW_RC, 3'd`SW_W1C, 3'd`SW_RW};
  localparam logic [N-1:0]   PRI = 7'b0110111;
  localparam logic [3:0]     RV  = 4'hA;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] sw_wr, sw_rd, hw_modify, collision_clr;
  logic [N-1:0] rd_valid, field_changed, collision;
  logic [3:0]   sw_wdata [N];
  logic [3:0]   nxt_hw_value [N];
  logic [3:0]   field_value [N];
  logic [3:0]   sw_rdata [N];

  logic [3:0] m_field [N];
  logic [3:0] m_rdata [N];
  logic       m_rdv [N];
  logic       m_chg [N];
  logic       m_col [N];
  logic [3:0] n_field [N];
  logic [3:0] n_rdata [N];
  logic       n_rdv [N];
  logic       n_chg [N];
  logic       n_col [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    xreg_field #(
      .F_WIDTH(4), .RST_VAL(RV), .SW_TYPE(int'(TYS[g*3 +: 3])), .HW_PRI(PRI[g])
    ) u_dut (
      .clk(clk), .rst(rst),
      .sw_wr(sw_wr[g]), .sw_rd(sw_rd[g]), .sw_wdata(sw_wdata[g]),
      .hw_modify(hw_modify[g]), .nxt_hw_value(nxt_hw_value[g]),
      .collision_clr(collision_clr[g]),
      .field_value(field_value[g]), .sw_rdata(sw_rdata[g]),
      .rd_valid(rd_valid[g]), .field_changed(field_changed[g]),
      .collision(collision[g])
    );
  end

  function automatic int ty(input int i);
    return int'(TYS[i*3 +: 3]);
  endfunction

  task automatic chk(input string tag, input int i, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    sw_wr = '0; sw_rd = '0; hw_modify = '0; collision_clr = '0;
    for (int i = 0; i < N; i++) begin
      sw_wdata[i] = '0;
      nxt_hw_value[i] = '0;
    end
  endtask

  // Field behaviour from the access-type rules: which side writes, and what.
  task automatic model(input int i);
    logic       sw_hit;
    logic [3:0] sw_val;
    sw_hit = 1'b0;
    sw_val = m_field[i];
    case (ty(i))
      `SW_RW, `SW_WO: begin sw_hit = sw_wr[i]; sw_val = sw_wdata[i]; end
      `SW_W1C: begin sw_hit = sw_wr[i]; sw_val = m_field[i] & ~sw_wdata[i]; end
      `SW_W1S: begin sw_hit = sw_wr[i]; sw_val = m_field[i] | sw_wdata[i]; end
      `SW_RC:  begin sw_hit = sw_rd[i]; sw_val = 4'h0; end
      default: ;
    endcase
    if (rst) begin
      n_field[i] = RV; n_rdata[i] = 4'h0; n_rdv[i] = 1'b0; n_chg[i] = 1'b0; n_col[i] = 1'b0;
    end else begin
      if (hw_modify[i] && sw_hit) n_field[i] = PRI[i] ? nxt_hw_value[i] : sw_val;
      else if (hw_modify[i])      n_field[i] = nxt_hw_value[i];
      else if (sw_hit)            n_field[i] = sw_val;
      else                        n_field[i] = m_field[i];
      n_chg[i]   = (n_field[i] != m_field[i]);
      n_rdv[i]   = sw_rd[i];
      n_rdata[i] = sw_rd[i] ? ((ty(i) == `SW_WO) ? 4'h0 : m_field[i]) : m_rdata[i];
      n_col[i]   = (hw_modify[i] && sw_hit) || (m_col[i] && !collision_clr[i]);
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < N; i++) model(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_field[i] = n_field[i]; m_rdata[i] = n_rdata[i]; m_rdv[i] = n_rdv[i];
      m_chg[i] = n_chg[i]; m_col[i] = n_col[i];
      chk("field_value", i, field_value[i], m_field[i]);
      chk("rd_valid", i, {3'b0, rd_valid[i]}, {3'b0, m_rdv[i]});
      chk("field_changed", i, {3'b0, field_changed[i]}, {3'b0, m_chg[i]});
      chk("collision", i, {3'b0, collision[i]}, {3'b0, m_col[i]});
      if (m_rdv[i]) chk("sw_rdata", i, sw_rdata[i], m_rdata[i]);
    end
  endtask

  task automatic hw_set(input int i, input logic [3:0] v);
    idle_inputs();
    hw_modify[i] = 1'b1; nxt_hw_value[i] = v;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cycle();
    // reset dominates every strobe
    sw_wr = '1; sw_rd = '1; hw_modify = '1;
    for (int i = 0; i < N; i++) begin sw_wdata[i] = 4'h5; nxt_hw_value[i] = 4'h3; end
    cycle();
    chk("rst_field", 0, field_value[0], 4'hA);
    chk("rst_rdv", 2, {3'b0, rd_valid[2]}, 4'h0);
    rst = 1'b0;
    idle_inputs();
    cycle();
    chk("idle_field", 5, field_value[5], 4'hA);

    // RW write, read, rewrite same value
    idle_inputs(); sw_wr[0] = 1'b1; sw_wdata[0] = 4'h5; cycle();
    chk("rw_field", 0, field_value[0], 4'h5);
    chk("rw_chg", 0, {3'b0, field_changed[0]}, 4'h1);
    idle_inputs(); sw_rd[0] = 1'b1; cycle();
    chk("rw_rdata", 0, sw_rdata[0], 4'h5);
    idle_inputs(); sw_wr[0] = 1'b1; sw_wdata[0] = 4'h5; cycle();
    chk("rw_same_chg", 0, {3'b0, field_changed[0]}, 4'h0);

    // W1C clear, then collision with HW winning, sticky, set beats clear
    hw_set(1, 4'hF);
    idle_inputs(); sw_wr[1] = 1'b1; sw_wdata[1] = 4'h3; cycle();
    chk("w1c_field", 1, field_value[1], 4'hC);
    idle_inputs(); sw_wr[1] = 1'b1; sw_wdata[1] = 4'h3; hw_modify[1] = 1'b1; nxt_hw_value[1] = 4'h1; cycle();
    chk("w1c_hwwin", 1, field_value[1], 4'h1);
    chk("w1c_col", 1, {3'b0, collision[1]}, 4'h1);
    idle_inputs(); cycle();
    idle_inputs(); collision_clr[1] = 1'b1; sw_wr[1] = 1'b1; sw_wdata[1] = 4'h1;
    hw_modify[1] = 1'b1; nxt_hw_value[1] = 4'h2; cycle();
    chk("col_set_wins", 1, {3'b0, collision[1]}, 4'h1);
    idle_inputs(); collision_clr[1] = 1'b1; cycle();
    chk("col_clr", 1, {3'b0, collision[1]}, 4'h0);

    // RC with incrementing controller
    for (int k = 2; k <= 3; k++) hw_set(k, 4'hF);
    idle_inputs(); hw_modify[3:2] = 2'b11; nxt_hw_value[2] = 4'h0; nxt_hw_value[3] = 4'h0; cycle();
    chk("rc_wrap", 2, field_value[2], 4'h0);
    hw_set(2, 4'h3);
    idle_inputs(); sw_rd[2] = 1'b1; cycle();
    chk("rc_rd", 2, sw_rdata[2], 4'h3);
    chk("rc_clr", 2, field_value[2], 4'h0);
    idle_inputs(); hw_modify[3:2] = 2'b11; nxt_hw_value[2] = 4'h3; nxt_hw_value[3] = 4'h3; cycle();
    idle_inputs(); sw_rd[3:2] = 2'b11; hw_modify[3:2] = 2'b11;
    nxt_hw_value[2] = 4'h4; nxt_hw_value[3] = 4'h4; cycle();
    chk("rc_hw_rdata", 2, sw_rdata[2], 4'h3);
    chk("rc_hw_field", 2, field_value[2], 4'h4);
    chk("rc_hw_col", 2, {3'b0, collision[2]}, 4'h1);
    chk("rc_sw_field", 3, field_value[3], 4'h0);

    // WO reads zero
    idle_inputs(); sw_wr[4] = 1'b1; sw_wdata[4] = 4'h9; cycle();
    idle_inputs(); sw_rd[4] = 1'b1; cycle();
    chk("wo_rdv", 4, {3'b0, rd_valid[4]}, 4'h1);
    chk("wo_rdata", 4, sw_rdata[4], 4'h0);
    chk("wo_field", 4, field_value[4], 4'h9);

    // RO with wired controller
    for (int v = 1; v <= 3; v++) begin
      idle_inputs(); hw_modify[5] = 1'b1; nxt_hw_value[5] = 4'(v);
      sw_wr[5] = 1'b1; sw_wdata[5] = 4'hE; cycle();
      chk("ro_follow", 5, field_value[5], 4'(v));
      chk("ro_nocol", 5, {3'b0, collision[5]}, 4'h0);
    end

    // reset mid-read
    idle_inputs(); sw_rd = '1; rst = 1'b1; cycle();
    chk("rst_rd", 0, {3'b0, rd_valid[0]}, 4'h0);
    rst = 1'b0;

    // random back-to-back traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        sw_wr[i] = 1'($urandom); sw_rd[i] = 1'($urandom);
        hw_modify[i] = ($urandom_range(0, 2) == 0);
        collision_clr[i] = ($urandom_range(0, 3) == 0);
        sw_wdata[i] = 4'($urandom); nxt_hw_value[i] = 4'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
